// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared timing constants, rectangle types and helper functions for the
// mask stream generator. The timing counter and the rectangle/centroid logic
// in the top module both use these definitions.
//
// Contents:
//    IMG_W/IMG_H, porches and sync widths, derived H_TOTAL/V_TOTAL
//    rect_t    : rectangle as supplied on the input ports (x0, y0, w, h)
//    clip_t    : rectangle clipped to the active image, 12-bit coordinates
//    clipRect  : clips a rect_t against the active image
//    midpoint  : floor midpoint of a half-open interval [lo, hi)
package video_timing_pkg;

   localparam int IMG_W  = 64;
   localparam int IMG_H  = 64;
   localparam int H_FP   = 2;
   localparam int H_SYNC = 4;
   localparam int H_BP   = 2;
   localparam int V_FP   = 1;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 1;

   localparam int H_TOTAL = IMG_W + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = IMG_H + V_FP + V_SYNC + V_BP;

   localparam int COORD_W     = 11;
   localparam int CALC_W      = 12;
   localparam int FRAME_CNT_W = 16;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [CALC_W-1:0]  calc_t;

   typedef struct packed {
      coord_t x0;
      coord_t y0;
      coord_t w;
      coord_t h;
   } rect_t;

   typedef struct packed {
      calc_t x0;
      calc_t x1;
      calc_t y0;
      calc_t y1;
      logic  valid;
   } clip_t;

   localparam calc_t IMG_W_C = calc_t'(IMG_W);
   localparam calc_t IMG_H_C = calc_t'(IMG_H);

   // The end coordinate is formed one bit wider than the inputs so that
   // x0+w can never wrap, then clamped to the image edge. A rectangle that
   // starts at or beyond the edge ends up with x1 <= x0 and is reported empty.
   function automatic clip_t clipRect(input rect_t r);
      clip_t c;
      calc_t xEnd;
      calc_t yEnd;
      xEnd    = {1'b0, r.x0} + {1'b0, r.w};
      yEnd    = {1'b0, r.y0} + {1'b0, r.h};
      c.x0    = {1'b0, r.x0};
      c.y0    = {1'b0, r.y0};
      c.x1    = (xEnd < IMG_W_C) ? xEnd : IMG_W_C;
      c.y1    = (yEnd < IMG_H_C) ? yEnd : IMG_H_C;
      c.valid = (c.x1 > c.x0) && (c.y1 > c.y0);
      return c;
   endfunction

   // Floor of the centre of the inclusive span [lo, hi-1]. Only meaningful
   // for a non-empty span; callers force the result to 0 otherwise.
   function automatic coord_t midpoint(input calc_t lo, input calc_t hi);
      calc_t sum;
      sum = lo + hi - calc_t'(1);
      return sum[CALC_W-1:1];
   endfunction

endpackage

// File: rtl/video_timing_counter.sv
// video_timing_counter
// Free-running horizontal/vertical position counters with the decoded
// video timing terms. Everything advances only on cycles with ce_i=1.
//
// Ports:
//    clk_i        : clock, rising edge
//    rst_ni       : asynchronous reset, active low
//    ce_i         : clock enable
//    hCnt_o       : current horizontal position (0..H_TOTAL-1)
//    vCnt_o       : current vertical position (0..V_TOTAL-1)
//    active_o     : current position is inside the active image (combinational)
//    frameWrap_o  : current position is the last one of the frame (combinational)
//    de_o         : registered active-video flag, one ce cycle behind the counters
//    hsync_o      : registered horizontal sync, one ce cycle behind the counters
//    vsync_o      : registered vertical sync, one ce cycle behind the counters
module video_timing_counter
   import video_timing_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               ce_i,
   output logic [COORD_W-1:0] hCnt_o,
   output logic [COORD_W-1:0] vCnt_o,
   output logic               active_o,
   output logic               frameWrap_o,
   output logic               de_o,
   output logic               hsync_o,
   output logic               vsync_o
);

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(IMG_W);
   localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(IMG_H);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(IMG_W + H_FP);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(IMG_W + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(IMG_H + V_FP);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(IMG_H + V_FP + V_SYNC);

   logic [COORD_W-1:0] hCnt_q;
   logic [COORD_W-1:0] hCnt_d;
   logic [COORD_W-1:0] vCnt_q;
   logic [COORD_W-1:0] vCnt_d;
   logic               hWrap;
   logic               vWrap;
   logic               deDec;
   logic               hsyncDec;
   logic               vsyncDec;
   logic               de_q;
   logic               hsync_q;
   logic               vsync_q;

   // Next position: the line counter only moves when the pixel counter wraps.
   always_comb begin
      hWrap  = (hCnt_q == H_LAST);
      vWrap  = (vCnt_q == V_LAST);
      hCnt_d = hWrap ? '0 : hCnt_q + COORD_W'(1);
      vCnt_d = vCnt_q;
      if (hWrap) begin
         vCnt_d = vWrap ? '0 : vCnt_q + COORD_W'(1);
      end
   end

   // Timing decode of the current position. vsync depends on the line only,
   // so it covers whole lines including their horizontal blanking.
   always_comb begin
      deDec    = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
      hsyncDec = (hCnt_q >= HS_START) && (hCnt_q < HS_END);
      vsyncDec = (vCnt_q >= VS_START) && (vCnt_q < VS_END);
   end

   // Counters and the registered timing outputs share one enable, so a
   // stalled cycle freezes position and outputs together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hCnt_q  <= '0;
         vCnt_q  <= '0;
         de_q    <= 1'b0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
      end else if (ce_i) begin
         hCnt_q  <= hCnt_d;
         vCnt_q  <= vCnt_d;
         de_q    <= deDec;
         hsync_q <= hsyncDec;
         vsync_q <= vsyncDec;
      end
   end

   assign hCnt_o      = hCnt_q;
   assign vCnt_o      = vCnt_q;
   assign active_o    = deDec;
   assign frameWrap_o = hWrap && vWrap;
   assign de_o        = de_q;
   assign hsync_o     = hsync_q;
   assign vsync_o     = vsync_q;

endmodule

// File: rtl/mask_stream_gen.sv
// mask_stream_gen
// Video timing generator that also produces a per-pixel mask for a
// rectangle and the expected floor centroid of that rectangle after
// clipping to the active image. The rectangle is sampled once per frame,
// on the first vsync position, and applies to the following frame.
//
// Ports:
//    clk        : clock, rising edge
//    rst        : asynchronous reset, active low
//    ce         : clock enable; nothing advances while ce=0
//    rect_x0/y0 : rectangle top-left corner
//    rect_w/h   : rectangle width and height
//    de         : active-video flag
//    hsync      : horizontal sync, active high
//    vsync      : vertical sync, active high
//    mask       : active pixel inside the latched rectangle
//    exp_x/y    : floor centroid of the clipped latched rectangle (0 if empty)
//    exp_valid  : clipped latched rectangle is non-empty
//    frame_cnt  : number of completed frames, wraps modulo 2^16
module mask_stream_gen
   import video_timing_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic [COORD_W-1:0]     rect_x0,
   input  logic [COORD_W-1:0]     rect_y0,
   input  logic [COORD_W-1:0]     rect_w,
   input  logic [COORD_W-1:0]     rect_h,
   output logic                   de,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   mask,
   output logic [COORD_W-1:0]     exp_x,
   output logic [COORD_W-1:0]     exp_y,
   output logic                   exp_valid,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam logic [COORD_W-1:0] V_LOAD = COORD_W'(IMG_H + V_FP);

   logic [COORD_W-1:0]     hCnt;
   logic [COORD_W-1:0]     vCnt;
   logic                   active;
   logic                   frameWrap;
   logic                   loadPos;
   rect_t                  rectIn;
   rect_t                  shadow_q;
   rect_t                  shadow_d;
   clip_t                  clip;
   logic                   maskDec;
   logic                   mask_q;
   logic [COORD_W-1:0]     expX_q;
   logic [COORD_W-1:0]     expX_d;
   logic [COORD_W-1:0]     expY_q;
   logic [COORD_W-1:0]     expY_d;
   logic                   expValid_q;
   logic                   expValid_d;
   logic [FRAME_CNT_W-1:0] frameCnt_q;
   logic [FRAME_CNT_W-1:0] frameCnt_d;

   video_timing_counter u_timing (
      .clk_i       (clk),
      .rst_ni      (rst),
      .ce_i        (ce),
      .hCnt_o      (hCnt),
      .vCnt_o      (vCnt),
      .active_o    (active),
      .frameWrap_o (frameWrap),
      .de_o        (de),
      .hsync_o     (hsync),
      .vsync_o     (vsync)
   );

   assign rectIn = {rect_x0, rect_y0, rect_w, rect_h};

   // The shadow copy is taken at the first position of the first vsync line,
   // well clear of active video, so a frame never sees a half-updated rectangle.
   always_comb begin
      loadPos  = (vCnt == V_LOAD) && (hCnt == '0);
      shadow_d = loadPos ? rectIn : shadow_q;
   end

   assign clip = clipRect(shadow_q);

   // Mask and centroid are both derived from the shadow as it stands before
   // this cycle's load, so the centroid follows the load by one ce cycle.
   always_comb begin
      maskDec    = active
                   && ({1'b0, hCnt} >= clip.x0) && ({1'b0, hCnt} < clip.x1)
                   && ({1'b0, vCnt} >= clip.y0) && ({1'b0, vCnt} < clip.y1);
      expValid_d = clip.valid;
      expX_d     = clip.valid ? midpoint(clip.x0, clip.x1) : '0;
      expY_d     = clip.valid ? midpoint(clip.y0, clip.y1) : '0;
      frameCnt_d = frameWrap ? frameCnt_q + FRAME_CNT_W'(1) : frameCnt_q;
   end

   // All rectangle-side state shares the counter's enable so stalls never
   // skip or repeat a load, a mask pixel or a frame count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q   <= '0;
         mask_q     <= 1'b0;
         expX_q     <= '0;
         expY_q     <= '0;
         expValid_q <= 1'b0;
         frameCnt_q <= '0;
      end else if (ce) begin
         shadow_q   <= shadow_d;
         mask_q     <= maskDec;
         expX_q     <= expX_d;
         expY_q     <= expY_d;
         expValid_q <= expValid_d;
         frameCnt_q <= frameCnt_d;
      end
   end

   assign mask      = mask_q;
   assign exp_x     = expX_q;
   assign exp_y     = expY_q;
   assign exp_valid = expValid_q;
   assign frame_cnt = frameCnt_q;

endmodule

// File: doc/mask_stream_gen.md
MASK_STREAM_GEN -- requirements
Module: mask_stream_gen

Interface
REQ-001 Parameters SHALL be: IMG_W 64 active pixels per line; IMG_H 64 active lines; H_FP 2; H_SYNC 4; H_BP 2; V_FP 1; V_SYNC 2; V_BP 1 (all in pixels or lines).
REQ-002 Derived constants SHALL be H_TOTAL = IMG_W+H_FP+H_SYNC+H_BP and V_TOTAL = IMG_H+V_FP+V_SYNC+V_BP.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 ce  in  1  clock enable; counters and outputs advance only when ce=1.
REQ-006 rect_x0, rect_y0  in  11 each  rectangle top-left corner.
REQ-007 rect_w, rect_h  in  11 each  rectangle width and height.
REQ-008 de  out  1  active-video flag.
REQ-009 hsync, vsync  out  1 each  active-high sync pulses.
REQ-010 mask  out  1  high on active pixels inside the latched rectangle.
REQ-011 exp_x, exp_y  out  11 each  expected floor centroid of the clipped rectangle.
REQ-012 exp_valid  out  1  clipped rectangle is non-empty.
REQ-013 frame_cnt  out  16  completed-frame count.

Function
REQ-014 h_cnt (0..H_TOTAL-1) SHALL increment on every ce cycle and wrap to 0, with v_cnt incrementing on that wrap and itself wrapping to 0 after V_TOTAL-1.
REQ-015 de SHALL be 1 iff h_cnt<IMG_W and v_cnt<IMG_H.
REQ-016 hsync SHALL be 1 iff IMG_W+H_FP <= h_cnt < IMG_W+H_FP+H_SYNC, on every line including vertical blanking.
REQ-017 vsync SHALL be 1 for entire lines with IMG_H+V_FP <= v_cnt < IMG_H+V_FP+V_SYNC.
REQ-018 de, hsync, vsync and mask SHALL be registered with exactly 1 ce-cycle latency from the counter state they decode; they SHALL hold their values while ce=0.
REQ-019 The shadow rectangle SHALL load from rect_* on the ce cycle where v_cnt=IMG_H+V_FP and h_cnt=0 (the first vsync cycle); rect_* changes at any other time SHALL have no effect until the next load.
REQ-020 Clipping SHALL use x1 = min(x0+w, IMG_W) and y1 = min(y0+h, IMG_H), computed in 12 bits so no overflow occurs.
REQ-021 mask SHALL be de AND x0<=h_cnt<x1 AND y0<=v_cnt<y1, using shadow values.
REQ-022 exp_valid SHALL be (x1>x0) AND (y1>y0); w=0, h=0, x0>=IMG_W and y0>=IMG_H SHALL each give exp_valid=0 and no mask pixels.
REQ-023 exp_x SHALL be (x0+x1-1)>>1 and exp_y SHALL be (y0+y1-1)>>1, both in 12-bit arithmetic and both 0 when exp_valid=0.
REQ-024 exp_x, exp_y and exp_valid SHALL update 1 cycle after the shadow load and stay stable for the whole following frame.
REQ-025 frame_cnt SHALL increment on the ce cycle where both counters wrap to (0,0), wrapping modulo 2^16.
REQ-026 The generator SHALL be a plain free-running counter pair with no FSM beyond that; ce=0 on any cycle, including the load cycle, SHALL only stall it and cause no skipped or duplicated position.

Reset
REQ-027 While rst=0, h_cnt, v_cnt, frame_cnt, the shadow rectangle and all outputs SHALL be 0, asynchronously.
REQ-028 After rst releases, the first ce cycle SHALL decode position (0,0).
REQ-029 The first frame after reset SHALL have mask=0 and exp_valid=0, because the shadow rectangle is still 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately and produce no partial frame_cnt increment.

Structure
REQ-031 Default timing constants and the derived H_TOTAL and V_TOTAL SHALL live in the shared package video_timing_pkg, which the centroid block also uses.
REQ-032 One sub-module, video_timing_counter, SHALL hold h_cnt and v_cnt, the wrap logic and the decoded de/hsync/vsync terms.
REQ-033 Rectangle shadow, clip logic, mask and expected-centroid logic SHALL be in the top module.

Verification
REQ-034 Reset then ce=1 constantly for 3 frames: frame_cnt=3 after 3*72*68 cycles; 4096 de cycles per frame; hsync 4 cycles per line; vsync 144 cycles per frame.
REQ-035 rect=(10,20,8,6) loaded: the next frame has 48 mask pixels and exp_x=13, exp_y=22, exp_valid=1.
REQ-036 rect=(60,62,10,10): clipped to 4x2, so 8 mask pixels, exp_x=61, exp_y=62.
REQ-037 rect_w=0, or rect_x0=70: mask never asserts and exp_valid=0, exp_x=0, exp_y=0.
REQ-038 Change rect_* mid-active-frame: the current frame's mask is unchanged and the new rectangle appears in the next frame only.
REQ-039 Random ce toggling (50%): the output sequence equals the ce=1 sequence with cycles where ce=0 removed; rst pulsed at v_cnt=30 restarts at (0,0) with all outputs 0.
